// File: rtl/ilkn_burst_framer.sv
// Interlaken burst framer: cuts the TX generator's word stream into bursts and packets,
// interleaving burst/idle control words ahead of the gearbox. CRC24 is left as zero.
module ilkn_burst_framer #(
  parameter int unsigned BURST_MAX     = 8,
  parameter int unsigned PACKET_BURSTS = 4,
  parameter logic [7:0]  CHANNEL       = 8'd0
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET_N,
  input  logic [63:0] TX_DATA_IN,
  input  logic        TX_DATA_VALID,
  output logic        DATA_IN_READY,
  output logic [63:0] TX_FRAME_OUT,
  output logic        TX_FRAME_CTRL,
  output logic        TX_FRAME_VALID,
  input  logic        TX_FRAME_READY
);

  localparam int unsigned DW = 64;
  localparam int unsigned BW = $clog2(BURST_MAX);
  localparam int unsigned PW = (PACKET_BURSTS > 1) ? $clog2(PACKET_BURSTS) : 1;
  localparam logic [3:0]  EOP_FULL = 4'b1000;
  localparam logic [3:0]  EOP_NONE = 4'b0000;

  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t        state, state_nx;
  logic [BW-1:0] burst_cnt, burst_cnt_nx;
  logic [PW-1:0] pkt_cnt, pkt_cnt_nx;
  logic [3:0]    pending_eop, pending_eop_nx;
  logic [DW-1:0] frame_nx;
  logic          ctrl_nx;
  logic          advance;

  // Burst/idle control word with XON asserted and CRC24 left for the downstream stage.
  function automatic logic [63:0] ctrl_word(input logic burst, input logic sop,
                                            input logic [3:0] eop);
    ctrl_word = {1'b1, burst, sop, eop, 1'b0, 16'hFFFF,
                 (burst ? CHANNEL : 8'h00), 32'h0000_0000};
  endfunction

  assign advance       = !TX_FRAME_VALID || TX_FRAME_READY;
  assign DATA_IN_READY = (state == S_DATA) && advance;

  always_comb begin
    state_nx       = state;
    burst_cnt_nx   = burst_cnt;
    pkt_cnt_nx     = pkt_cnt;
    pending_eop_nx = pending_eop;
    frame_nx       = TX_FRAME_OUT;
    ctrl_nx        = TX_FRAME_CTRL;
    case (state)
      S_IDLE: begin
        ctrl_nx        = 1'b1;
        pending_eop_nx = EOP_NONE;
        if (TX_DATA_VALID) begin
          frame_nx = ctrl_word(1'b1, (pkt_cnt == '0), pending_eop);
          state_nx = S_DATA;
        end else begin
          frame_nx = ctrl_word(1'b0, 1'b0, pending_eop);
        end
      end
      S_DATA: begin
        if (TX_DATA_VALID) begin
          frame_nx = TX_DATA_IN;
          ctrl_nx  = 1'b0;
          if (burst_cnt == BW'(BURST_MAX - 1)) begin
            burst_cnt_nx = '0;
            state_nx     = S_IDLE;
            // Last burst of the packet: EOP rides on the next control word.
            if (pkt_cnt == PW'(PACKET_BURSTS - 1)) begin
              pkt_cnt_nx     = '0;
              pending_eop_nx = EOP_FULL;
            end else begin
              pkt_cnt_nx = pkt_cnt + PW'(1);
            end
          end else begin
            burst_cnt_nx = burst_cnt + BW'(1);
          end
        end else begin
          frame_nx = ctrl_word(1'b0, 1'b0, EOP_NONE);
          ctrl_nx  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Everything advances together; a stalled output holds framer state as well.
  always_ff @(posedge USER_CLK or negedge SYSTEM_RESET_N) begin
    if (!SYSTEM_RESET_N) begin
      state          <= S_IDLE;
      burst_cnt      <= '0;
      pkt_cnt        <= '0;
      pending_eop    <= EOP_NONE;
      TX_FRAME_OUT   <= '0;
      TX_FRAME_CTRL  <= 1'b0;
      TX_FRAME_VALID <= 1'b0;
    end else if (advance) begin
      state          <= state_nx;
      burst_cnt      <= burst_cnt_nx;
      pkt_cnt        <= pkt_cnt_nx;
      pending_eop    <= pending_eop_nx;
      TX_FRAME_OUT   <= frame_nx;
      TX_FRAME_CTRL  <= ctrl_nx;
      TX_FRAME_VALID <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ilkn_burst_framer.sv
// Bench for ilkn_burst_framer: directed scenarios plus random VALID/READY traffic,
// checked against a word-count based reference model.
module tb_ilkn_burst_framer;

  localparam int unsigned BM = 8;
  localparam int unsigned PB = 4;
  localparam logic [7:0]  CH = 8'd5;

  logic        clk;
  logic        rst_n;
  logic [63:0] tx_data_in;
  logic        tx_data_valid;
  logic        data_in_ready;
  logic [63:0] tx_frame_out;
  logic        tx_frame_ctrl;
  logic        tx_frame_valid;
  logic        tx_frame_ready;

  ilkn_burst_framer #(.BURST_MAX(BM), .PACKET_BURSTS(PB), .CHANNEL(CH)) dut (
    .USER_CLK       (clk),
    .SYSTEM_RESET_N (rst_n),
    .TX_DATA_IN     (tx_data_in),
    .TX_DATA_VALID  (tx_data_valid),
    .DATA_IN_READY  (data_in_ready),
    .TX_FRAME_OUT   (tx_frame_out),
    .TX_FRAME_CTRL  (tx_frame_ctrl),
    .TX_FRAME_VALID (tx_frame_valid),
    .TX_FRAME_READY (tx_frame_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: total data words sent, whether a burst header is open, owed EOP.
  int          words_total;
  bit          in_burst;
  bit          eop_owed;
  bit          m_valid;
  logic [63:0] exp_out;
  logic        exp_ctrl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] cw(input bit burst, input bit sop, input bit eop);
    logic [63:0] w;
    w = 64'h0;
    w[63]    = 1'b1;
    w[62]    = burst;
    w[61]    = sop;
    w[60:57] = eop ? 4'b1000 : 4'b0000;
    w[55:40] = 16'hFFFF;
    w[39:32] = burst ? CH : 8'h00;
    return w;
  endfunction

  task automatic model_reset();
    words_total = 0;
    in_burst    = 0;
    eop_owed    = 0;
    m_valid     = 0;
    exp_out     = '0;
    exp_ctrl    = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit r, input logic [63:0] d);
    if (!m_valid || r) begin
      m_valid = 1;
      if (!in_burst) begin
        exp_ctrl = 1'b1;
        if (v) begin
          exp_out  = cw(1, ((words_total / BM) % PB) == 0, eop_owed);
          in_burst = 1;
        end else begin
          exp_out = cw(0, 0, eop_owed);
        end
        eop_owed = 0;
      end else if (v) begin
        exp_out  = d;
        exp_ctrl = 1'b0;
        words_total++;
        if (words_total % BM == 0) in_burst = 0;
        if (words_total % (BM * PB) == 0) eop_owed = 1;
      end else begin
        exp_out  = cw(0, 0, 0);
        exp_ctrl = 1'b1;
      end
    end
  endtask

  // Called at a negedge: drive, check ready, clock, check outputs at the next negedge.
  task automatic cycle(input bit v, input bit r);
    logic [63:0] d;
    d = {$urandom, $urandom};
    tx_data_valid  = v;
    tx_frame_ready = r;
    tx_data_in     = d;
    #1;
    check("in_ready", 64'(data_in_ready), 64'(in_burst && (!m_valid || r)));
    @(posedge clk);
    model_step(v, r, d);
    @(negedge clk);
    check("frame_out", tx_frame_out, exp_out);
    check("frame_ctrl", 64'(tx_frame_ctrl), 64'(exp_ctrl));
    check("frame_valid", 64'(tx_frame_valid), 64'(m_valid));
  endtask

  initial begin
    rst_n          = 1'b0;
    tx_data_valid  = 1'b0;
    tx_frame_ready = 1'b1;
    tx_data_in     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out", tx_frame_out, 64'h0);
    check("rst_valid", 64'(tx_frame_valid), 64'h0);
    rst_n = 1'b1;

    // Idle stream after reset
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1);
      check("idle_word", tx_frame_out, 64'h80FFFF0000000000);
    end

    // Full packet at line rate, then SOP+EOP header
    cycle(1, 1);
    check("first_hdr", tx_frame_out, 64'hE0FFFF0500000000);
    for (int i = 0; i < 35; i++) cycle(1, 1);
    cycle(1, 1);
    check("eop_sop_hdr", tx_frame_out, 64'hF0FFFF0500000000);

    // Second packet, then go idle straight after its last word
    for (int i = 0; i < 35; i++) cycle(1, 1);
    cycle(0, 1);
    check("idle_eop", tx_frame_out, 64'h90FFFF0000000000);
    cycle(0, 1);
    check("idle_after_eop", tx_frame_out, 64'h80FFFF0000000000);

    // Mid-burst source gap and downstream stall
    cycle(1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1);
    cycle(0, 1);
    check("gap_idle", tx_frame_out, 64'h80FFFF0000000000);
    cycle(0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 0);
    for (int i = 0; i < 6; i++) cycle(1, 1);

    // Random traffic
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0);

    // Reset in the middle of a burst
    cycle(0, 1);
    while (!in_burst) cycle(1, 1);
    cycle(1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", tx_frame_out, 64'h0);
    check("midrst_valid", 64'(tx_frame_valid), 64'h0);
    check("midrst_ctrl", 64'(tx_frame_ctrl), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 1);
    check("post_rst_hdr", tx_frame_out, 64'hE0FFFF0500000000);
    for (int i = 0; i < 20; i++) cycle(1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ilkn_burst_framer.md
Name: ilkn_burst_framer

Overview:
- Sits directly downstream of the ROM-based TX frame generator, between it and the TX gearbox/GT lane logic.
- Consumes the generator's 64-bit word stream through a valid/ready handshake, cuts it into Interlaken bursts of BURST_MAX words, and groups every PACKET_BURSTS bursts into one packet.
- Emits a single 64-bit stream with a control flag: burst control words, data words and idle control words.
- CRC24 field is emitted as zero; the downstream CRC stage fills it.

Parameters:
- BURST_MAX, 8, data words per burst (>=2).
- PACKET_BURSTS, 4, bursts per packet (>=1).
- CHANNEL, 8'd0, channel number placed in burst control words.

Ports:
- USER_CLK  in  1  system clock, all logic on rising edge.
- SYSTEM_RESET_N  in  1  asynchronous active-low reset.
- TX_DATA_IN  in  64  data word from the frame generator.
- TX_DATA_VALID  in  1  TX_DATA_IN is valid.
- DATA_IN_READY  out  1  framer accepts TX_DATA_IN this cycle; a transfer occurs when VALID && READY.
- TX_FRAME_OUT  out  64  framed word.
- TX_FRAME_CTRL  out  1  1 = control word, 0 = data word.
- TX_FRAME_VALID  out  1  TX_FRAME_OUT is valid.
- TX_FRAME_READY  in  1  downstream accepts the framed word.

Behaviour:
- Reset (async assert, sync release): TX_FRAME_OUT=0, TX_FRAME_CTRL=0, TX_FRAME_VALID=0. State=S_IDLE; burst_cnt=0, pkt_cnt=0, pending_eop=4'b0000.
- Output register: advance = !TX_FRAME_VALID || TX_FRAME_READY. The register loads only on advance.
  - TX_FRAME_VALID goes to 1 on the first clock after reset release and stays 1; the framer always emits a word.
  - While advance=0, all outputs hold stable.
- DATA_IN_READY = (state==S_DATA) && advance. This is combinational and is never asserted in S_IDLE.
- Control word layout:
  - [63]=1; [62]=1 burst / 0 idle; [61]=SOP; [60:57]=EOP_Format; [56]=0.
  - [55:40]=16'hFFFF (XON); [39:32]=CHANNEL for burst words, 8'h00 for idle words; [31:0]=0.
  - EOP_Format 4'b1000 = EOP with all 8 bytes valid; 4'b0000 = no EOP.
- S_IDLE, on advance:
  - If TX_DATA_VALID: emit a burst control word with SOP=(pkt_cnt==0) and EOP=pending_eop; clear pending_eop; go to S_DATA. No data is consumed on this cycle.
  - Else: emit an idle control word with EOP=pending_eop, clear pending_eop, stay in S_IDLE.
- S_DATA, on advance:
  - If TX_DATA_VALID: emit TX_DATA_IN with CTRL=0; this is the transfer; burst_cnt++.
    - When burst_cnt==BURST_MAX-1: burst_cnt←0 and go to S_IDLE.
    - At that point, if pkt_cnt==PACKET_BURSTS-1: pkt_cnt←0 and pending_eop←4'b1000; otherwise pkt_cnt++.
  - Else: emit an idle control word with EOP=0000 (mid-burst idle). Stay in S_DATA with counters unchanged.
- EOP of a packet always rides on the control word that immediately follows its final data word, whether that word is a burst or an idle word.
- Latency: an accepted input word appears on TX_FRAME_OUT on the next clock edge.
- Throughput with continuous VALID and READY: BURST_MAX data words per BURST_MAX+1 cycles.
- Reset mid-burst discards the partial burst and packet; the next burst after reset carries SOP=1 and EOP=0.

Test Plan:
1. Reset release, TX_DATA_VALID=0, TX_FRAME_READY=1 for 5 cycles -> DATA_IN_READY=0; every output word is CTRL=1, 64'h80FFFF0000000000.
2. CHANNEL=5, defaults, VALID=READY=1 -> first word 64'hE0FFFF0500000000; then 8 data words equal to input order; then 64'hC0FFFF0500000000 three times between bursts; after the 32nd data word, 64'hF0FFFF0500000000 (EOP + new SOP).
3. Mid-stream, TX_FRAME_READY=0 for 3 cycles -> TX_FRAME_OUT/CTRL/VALID stable and DATA_IN_READY=0 throughout; no word dropped or duplicated after release.
4. TX_DATA_VALID=0 for 2 cycles after the 3rd data word of a burst -> two idle words 64'h80FFFF0000000000; the remaining 5 data words follow, then a burst control word.
5. TX_DATA_VALID=0 immediately after the 32nd data word -> 64'h90FFFF0000000000 (idle + EOP), then 64'h80FFFF0000000000.
6. SYSTEM_RESET_N pulsed low mid-burst (between clock edges) -> outputs clear to 0 immediately; after release, the first burst control word has SOP=1, EOP=0.
